// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out bus between the byte stage, the packer and the word consumer.
interface byte_word_packer_if #(
  parameter int unsigned AW = 2
);
  logic          i_valid;
  logic [7:0]    i_in;
  logic          i_clear;
  logic          o_valid;
  logic [31:0]   o_data;
  logic          i_ready;
  logic [AW:0]   o_level;
  logic          o_full;
  logic          o_ovf;

  modport master (
    output i_valid, i_in, i_clear, i_ready,
    input  o_valid, o_data, o_level, o_full, o_ovf
  );

  modport slave (
    input  i_valid, i_in, i_clear, i_ready,
    output o_valid, o_data, o_level, o_full, o_ovf
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs qualified bytes little-endian into 32-bit words and buffers them in a
// first-word-fall-through FIFO; words completing while full are dropped.
module byte_word_packer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input logic                clk,
  input logic                rst_x,
  byte_word_packer_if.slave  bus
);
  localparam int unsigned LVL_W  = AW + 1;
  localparam int unsigned WORD_W = 32;

  logic [1:0]        cnt;
  logic [23:0]       part;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              ovf;

  logic              full;
  logic              pop;
  logic              push_req;
  logic              push;
  logic [WORD_W-1:0] word;

  // Handshake decode; a pop frees a slot for a same-cycle push when full.
  always_comb begin
    full     = (level == LVL_W'(DEPTH));
    pop      = (level != '0) & bus.i_ready;
    push_req = bus.i_valid & (cnt == 2'd3);
    push     = push_req & (~full | pop);
    word     = {bus.i_in, part};
  end

  // Partial-word assembly; the count wraps on completion even if the word is dropped.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cnt  <= '0;
      part <= '0;
    end else if (bus.i_clear) begin
      cnt  <= '0;
    end else if (bus.i_valid) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    part[7:0]   <= bus.i_in;
        2'd1:    part[15:8]  <= bus.i_in;
        2'd2:    part[23:16] <= bus.i_in;
        default: ;
      endcase
    end
  end

  // Word storage; reset to zero so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (!bus.i_clear && push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Pointers, level and sticky overflow; clear overrides push and pop.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (bus.i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  // Head of the FIFO is read straight from storage.
  assign bus.o_valid = (level != '0);
  assign bus.o_data  = mem[rd_ptr];
  assign bus.o_level = level;
  assign bus.o_full  = full;
  assign bus.o_ovf   = ovf;
endmodule
